// File: rtl/regfile_pkg.sv
// Shared register-file constants used by the writeback arbiter and its users.
package regfile_pkg;

  localparam int unsigned DEFAULT_NUM_REGS   = 32;
  localparam int unsigned REG_ADDR_W         = $clog2(DEFAULT_NUM_REGS);
  localparam int unsigned DEFAULT_DATA_WIDTH = 32;
  localparam int unsigned DEFAULT_NUM_REQ    = 3;

  // Architectural zero register; writes to it are swallowed.
  localparam int unsigned REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_picker.sv
// Combinational picker: first set request at or after start_i, wrapping modulo N.
module rr_picker #(
  parameter int unsigned N    = 3,
  parameter int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] start_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] idx_o
);

  logic            found;
  logic [IdxW:0]   cand;

  // Scan N candidates starting at start_i; the first valid one wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned off = 0; off < N; off++) begin
      cand = {1'b0, start_i} + (IdxW + 1)'(off);
      if (cand >= (IdxW + 1)'(N)) begin
        cand = cand - (IdxW + 1)'(N);
      end
      if (!found && req_i[cand[IdxW-1:0]]) begin
        found                 = 1'b1;
        idx_o                 = cand[IdxW-1:0];
        gnt_o[cand[IdxW-1:0]] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter: shares the register-file write port among NUM_REQ requesters.
// Build option: define REGFILE_WB_RR_EN for round-robin; otherwise fixed priority (index 0 first).
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NUM_REQ             = DEFAULT_NUM_REQ,
  parameter int unsigned NUMBER_OF_REGISTERS = DEFAULT_NUM_REGS,
  parameter int unsigned DATA_WIDTH          = DEFAULT_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH           = 16
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic [NUM_REQ-1:0]                          req_valid_i,
  output logic [NUM_REQ-1:0]                          req_ready_o,
  input  logic [NUM_REQ*$clog2(NUMBER_OF_REGISTERS)-1:0] req_addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]               req_data_i,
  output logic                                        wr_en_o,
  output logic [$clog2(NUMBER_OF_REGISTERS)-1:0]      wr_addr_o,
  output logic [DATA_WIDTH-1:0]                       wr_data_o,
  output logic                                        wb_stall_o,
  output logic [CNT_WIDTH-1:0]                        conflict_cnt_o,
  input  logic                                        conflict_clr_i
);

  localparam int unsigned AW   = $clog2(NUMBER_OF_REGISTERS);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    gnt;
  logic [IdxW-1:0]       idx;
  logic [IdxW-1:0]       start;
  logic                  hs;
  logic [AW-1:0]         win_addr;
  logic [DATA_WIDTH-1:0] win_data;
  logic                  multi;

  logic                  wr_en_q, wr_en_d;
  logic [AW-1:0]         wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

  rr_picker #(
    .N    (NUM_REQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (req_valid_i),
    .start_i (start),
    .gnt_o   (gnt),
    .idx_o   (idx)
  );

`ifdef REGFILE_WB_RR_EN
  logic [IdxW-1:0] ptr_q, ptr_d;

  // Pointer moves just past the winner after every grant, including x0 grants.
  always_comb begin
    ptr_d = ptr_q;
    if (hs) begin
      ptr_d = (idx == IdxW'(NUM_REQ - 1)) ? '0 : idx + IdxW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign start = ptr_q;
`else
  assign start = '0;
`endif

  // Handshake, grant gating during reset, and stall/contention detection.
  always_comb begin
    req_ready_o = rst_n ? gnt : '0;
    hs          = |req_ready_o;
    wb_stall_o  = rst_n & (|(req_valid_i & ~gnt));
    win_addr    = req_addr_i[int'(idx) * AW +: AW];
    win_data    = req_data_i[int'(idx) * DATA_WIDTH +: DATA_WIDTH];
    // Two or more bits set iff clearing the lowest set bit leaves something.
    multi       = |(req_valid_i & (req_valid_i - NUM_REQ'(1)));
  end

  // Next state of the write stage and the saturating contention counter.
  always_comb begin
    wr_en_d   = hs && (win_addr != AW'(REG_ZERO));
    wr_addr_d = hs ? win_addr : wr_addr_q;
    wr_data_d = hs ? win_data : wr_data_q;
    cnt_d     = cnt_q;
    if (conflict_clr_i) begin
      cnt_d = '0;
    end else if (multi && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  // Registered write port and counter; reset drops any accepted-but-undriven write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      cnt_q     <= '0;
    end else begin
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      cnt_q     <= cnt_d;
    end
  end

  assign wr_en_o        = wr_en_q;
  assign wr_addr_o      = wr_addr_q;
  assign wr_data_o      = wr_data_q;
  assign conflict_cnt_o = cnt_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Shares the register file's single write port between several writeback requesters (ALU, load unit, CSR unit) using a valid/ready handshake. Each cycle it grants at most one requester, then drives the register file write port from a registered stage one cycle later. It sits between the writeback sources and the register file. It also exports a stall to decode and a saturating contention counter.

## Interface
Parameters:
- NUM_REQ, 3, number of writeback requesters (2..8)
- NUMBER_OF_REGISTERS, 32, register count; address width is $clog2 of this
- DATA_WIDTH, 32, write data width
- CNT_WIDTH, 16, contention counter width

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  NUM_REQ  requester i has a write pending
- req_ready  out  NUM_REQ  requester i accepted this cycle; combinational, one-hot or zero
- req_addr  in  NUM_REQ*AW  packed destination addresses; slice i belongs to requester i
- req_data  in  NUM_REQ*DATA_WIDTH  packed write data
- wr_en  out  1  register file write enable
- wr_addr  out  AW  register file write address
- wr_data  out  DATA_WIDTH  register file write data
- wb_stall  out  1  a valid requester was not granted this cycle
- conflict_cnt  out  CNT_WIDTH  saturating count of contention cycles
- conflict_clr  in  1  synchronous clear of conflict_cnt

## Operation
- Grant:
  - The winner is the first requester i with req_valid[i]=1, searching from ptr upward with modulo wrap.
  - req_ready[winner]=1; all other bits are 0.
  - If no requester is valid, req_ready is 0.
- Acceptance: a handshake is req_valid[i] & req_ready[i]. The requester may drop or change its request in the next cycle.
- Write stage, registered on the cycle after acceptance:
  - wr_en = 1, with wr_addr and wr_data taken from the winner's slice.
  - If no handshake occurred, wr_en = 0 and wr_addr/wr_data hold their last values.
- Writes to address 0:
  - The request is accepted (req_ready=1).
  - wr_en stays 0, so register 0 is never written.
  - It still counts as a grant for pointer update.
- Pointer ptr:
  - After a grant, ptr becomes (winner+1) mod NUM_REQ.
  - With no grant, ptr holds its value.
- wb_stall = |(req_valid & ~req_ready). It is combinational.
- conflict_cnt:
  - Increments by 1 in each cycle where two or more bits of req_valid are set.
  - Saturates at all-ones.
  - conflict_clr has priority over the increment and sets the count to 0.
- Same-address requests from two requesters in the same cycle: only the winner is accepted. The loser writes in a later cycle, so the later write wins in the register file.
- The arbiter does no read forwarding; the register file handles same-cycle write/read bypass.

## Timing
- Reset (rst_n low, asynchronous) sets:
  - wr_en=0, wr_addr=0, wr_data=0
  - ptr=0, conflict_cnt=0
- While rst_n is low, req_ready=0 and wb_stall=0.
- Latency: handshake in cycle N produces the write-port write on edge N+1. Throughput is 1 write per cycle.
- Reset mid-operation: a write that was accepted but not yet driven is discarded. Owners of the requesters reset together with the arbiter.
- Fairness: with every requester continuously valid, each requester is granted once in every NUM_REQ cycles.
- req_ready depends combinationally on req_valid and ptr. Requesters must not derive req_valid from req_ready.

## Configuration
- REGFILE_WB_RR_EN
  - Defined: round-robin arbitration as described.
  - Undefined: fixed priority, where the lowest index wins. ptr is removed and the search always starts at 0.
- Handshake, write stage and counter behaviour are identical in both builds.

## Structure
- Shared package regfile_pkg holds:
  - the address-width constant REG_ADDR_W = $clog2(NUMBER_OF_REGISTERS)
  - the default DATA_WIDTH
  - the default NUM_REQ
  - the x0 address constant REG_ZERO
- One sub-module, rr_picker. It is combinational.
  - Inputs: request vector and start pointer.
  - Outputs: one-hot grant and winner index.
  - With REGFILE_WB_RR_EN undefined, the start pointer is tied to 0.

## Test plan
- Reset: hold rst_n low with all req_valid=1 -> wr_en=0, req_ready=0, conflict_cnt=0. Release -> the first grant goes to requester 0.
- Single requester: req 1 sends addr 5, data 0xDEADBEEF in cycle N -> req_ready[1]=1 in cycle N; wr_en=1, wr_addr=5, wr_data=0xDEADBEEF after edge N+1; wr_en=0 the cycle after.
- Full contention: NUM_REQ=3, all valid for 6 cycles -> grants 0,1,2,0,1,2; wb_stall=1 every cycle; conflict_cnt=6. Without the macro, grants are 0,0,0,0,0,0.
- x0 write: req 0 sends addr 0 -> req_ready[0]=1, wr_en stays 0, ptr advances to 1.
- Counter: CNT_WIDTH=4 with 20 contention cycles -> conflict_cnt=15. conflict_clr together with contention -> next value 0.
- Async reset mid-transfer: rst_n falls between handshake and the write edge -> wr_en=0 immediately, no write occurs, ptr=0.
